// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin front end sharing one pipelined divider among requesters
module div_arbiter #(
  parameter int BITS    = 8,
  parameter int STAGES  = BITS,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAX_OUT = 4,
  parameter int LAT     = STAGES + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*BITS-1:0]   req_dividend,
  input  logic [NREQ*BITS-1:0]   req_divisor,
  output logic [NREQ-1:0]        resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [STAGES-1:0]      resp_quotient,
  output logic                   resp_div_by_zero,
  output logic                   div_rst_n,
  output logic                   div_start,
  output logic [BITS-1:0]        div_dividend,
  output logic [BITS-1:0]        div_divisor,
  input  logic                   div_data_valid,
  input  logic                   div_div_by_zero,
  input  logic [STAGES-1:0]      div_quotient,
  output logic                   idle,
  output logic                   proto_err
);

  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   outstanding [NREQ];
  logic [LAT-1:0]  tag_vld;
  logic [IDW-1:0]  tag_id [LAT];

  logic [NREQ-1:0] eligible;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  int              idx;

  // A response strobing this cycle hands its credit straight back, so a
  // requester at the cap can be granted in the same cycle its result returns.
  always_comb begin
    eligible = '0;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & ~rst & ((outstanding[i] < MAX_C) | resp_valid[i]);
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  // Drive the grant and steer the winner's operands to the divider.
  always_comb begin
    req_ready    = '0;
    div_start    = gnt_any;
    div_dividend = '0;
    div_divisor  = '0;
    if (gnt_any) begin
      req_ready[gnt_id] = 1'b1;
      div_dividend      = req_dividend[int'(gnt_id)*BITS +: BITS];
      div_divisor       = req_divisor[int'(gnt_id)*BITS +: BITS];
    end
  end

  assign div_rst_n = ~rst;

  // Idle only when nothing is in the tag pipe, no strobe is out, and no credits are held.
  always_comb begin
    idle = (tag_vld == '0) && (resp_valid == '0);
    for (int i = 0; i < NREQ; i++) begin
      if (outstanding[i] != '0) idle = 1'b0;
    end
  end

  // Round-robin pointer moves to just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Tag pipe mirrors the divider latency; the tail lines up with div_data_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= gnt_any;
      tag_id[0]  <= gnt_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Register the result toward the requester named by the tail tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid       <= '0;
      resp_id          <= '0;
      resp_quotient    <= '0;
      resp_div_by_zero <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (tag_vld[LAT-1]) begin
        resp_valid[tag_id[LAT-1]] <= 1'b1;
        resp_id                   <= tag_id[LAT-1];
        resp_quotient             <= div_quotient;
        resp_div_by_zero          <= div_div_by_zero;
      end
    end
  end

  // Per-requester credit counters; simultaneous grant and return cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if ((gnt_any && gnt_id == IDW'(i)) && !resp_valid[i]) begin
          outstanding[i] <= outstanding[i] + 1'b1;
        end else if (!(gnt_any && gnt_id == IDW'(i)) && resp_valid[i]) begin
          outstanding[i] <= outstanding[i] - 1'b1;
        end
      end
    end
  end

  // Sticky flag when the divider's valid disagrees with our own tag tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (div_data_valid != tag_vld[LAT-1]) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter with a behavioural divider stand-in
module tb_div_arbiter;
  localparam int BITS = 8, STAGES = 8, NREQ = 4, IDW = 2, MAX_OUT = 4, LAT = STAGES + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_dividend = '0;
  logic [NREQ*BITS-1:0] req_divisor = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [STAGES-1:0]    resp_quotient;
  logic                 resp_div_by_zero;
  logic                 div_rst_n, div_start;
  logic [BITS-1:0]      div_dividend, div_divisor;
  logic                 div_data_valid, div_div_by_zero;
  logic [STAGES-1:0]    div_quotient;
  logic                 idle, proto_err;
  logic                 force_dv = 1'b0;

  div_arbiter #(.BITS(BITS), .STAGES(STAGES), .NREQ(NREQ), .IDW(IDW),
                .MAX_OUT(MAX_OUT), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_div_by_zero(resp_div_by_zero), .div_rst_n(div_rst_n), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_data_valid(div_data_valid), .div_div_by_zero(div_div_by_zero),
    .div_quotient(div_quotient), .idle(idle), .proto_err(proto_err));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h at cycle %0d", nm, act, exp, cyc);
  endfunction

  // Fixed-point quotient: dividend/divisor scaled by 2^(STAGES-1); all ones on divide by zero.
  function automatic logic [7:0] ref_quot(logic [7:0] a, logic [7:0] b);
    if (b == 0) return 8'hFF;
    return 8'((int'(a) * 128) / int'(b));
  endfunction

  // Behavioural divider: fixed latency LAT from start to data_valid.
  logic       dv_v [LAT];
  logic [7:0] dv_q [LAT];
  logic       dv_z [LAT];
  initial for (int i = 0; i < LAT; i++) begin dv_v[i] = 0; dv_q[i] = 0; dv_z[i] = 0; end
  always @(posedge clk) begin
    if (!div_rst_n) begin
      for (int i = 0; i < LAT; i++) dv_v[i] <= 1'b0;
    end else begin
      dv_v[0] <= div_start;
      dv_q[0] <= ref_quot(div_dividend, div_divisor);
      dv_z[0] <= (div_divisor == 0);
      for (int i = 1; i < LAT; i++) begin
        dv_v[i] <= dv_v[i-1]; dv_q[i] <= dv_q[i-1]; dv_z[i] <= dv_z[i-1];
      end
    end
  end
  assign div_data_valid  = dv_v[LAT-1] | force_dv;
  assign div_quotient    = dv_q[LAT-1];
  assign div_div_by_zero = dv_z[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [7:0] q; logic z; int c; } exp_t;
  exp_t sb[$];
  int grant_id_log[$], grant_cyc_log[$], resp_id_log[$], resp_cyc_log[$];

  // Reference model state
  int  rr_m = 0;
  int  out_m [NREQ] = '{default: 0};
  bit  proto_m = 0;

  // Arbitration model and issue-side checks; pushes expectations into the scoreboard.
  always @(negedge clk) begin
    int g, tot;
    exp_t e;
    logic [7:0] a, b;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int ix;
        ix = (rr_m + k) % NREQ;
        if (g < 0 && req_valid[ix] && (out_m[ix] < MAX_OUT || resp_valid[ix])) g = ix;
      end
    end
    a = (g >= 0) ? req_dividend[g*BITS +: BITS] : 8'h00;
    b = (g >= 0) ? req_divisor[g*BITS +: BITS] : 8'h00;
    tot = 0;
    for (int i = 0; i < NREQ; i++) tot += out_m[i];
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    chk("div_start", div_start, g >= 0);
    chk("div_dividend", div_dividend, a);
    chk("div_divisor", div_divisor, b);
    chk("idle", idle, tot == 0);
    chk("proto_err", proto_err, proto_m);
    chk("div_rst_n", div_rst_n, !rst);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin grant_id_log.push_back(i); grant_cyc_log.push_back(cyc); end
    if (rst) begin
      rr_m = 0; proto_m = 0;
      for (int i = 0; i < NREQ; i++) out_m[i] = 0;
    end else begin
      if (g >= 0) begin
        rr_m = (g + 1) % NREQ;
        out_m[g]++;
        e.id = g; e.q = ref_quot(a, b); e.z = (b == 0); e.c = cyc;
        sb.push_back(e);
      end
      for (int i = 0; i < NREQ; i++) if (resp_valid[i]) out_m[i]--;
      if (force_dv) proto_m = 1;
    end
  end

  // Response monitor: pops the scoreboard whenever a result is strobed.
  logic [IDW-1:0] last_id = 0;
  logic [7:0]     last_q = 0;
  logic           last_z = 0;
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid != 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_valid", resp_valid, 1 << e.id);
        chk("resp_id", resp_id, e.id);
        chk("resp_quotient", resp_quotient, e.q);
        chk("resp_div_by_zero", resp_div_by_zero, e.z);
        chk("resp_latency", cyc - e.c, LAT + 1);
        last_id = IDW'(e.id); last_q = e.q; last_z = e.z;
      end
      for (int i = 0; i < NREQ; i++)
        if (resp_valid[i]) begin resp_id_log.push_back(i); resp_cyc_log.push_back(cyc); end
    end else begin
      chk("resp_id_hold", resp_id, last_id);
      chk("resp_q_hold", resp_quotient, last_q);
      chk("resp_z_hold", resp_div_by_zero, last_z);
    end
    if (rst) begin
      sb.delete();
      last_id = 0; last_q = 0; last_z = 0;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(sb.size() == 0 && idle) && k < 60) begin step(); k++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic set_op(int r, logic [7:0] a, logic [7:0] b);
    req_dividend[r*BITS +: BITS] = a;
    req_divisor[r*BITS +: BITS]  = b;
  endtask

  initial begin
    int base, k;
    step(2);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_div_rst_n", div_rst_n, 0);
    chk("rst_proto", proto_err, 0);
    step();
    rst = 0;
    step();

    // single op
    set_op(0, 8'h20, 8'h40); req_valid = 4'b0001; step(); req_valid = 0;
    drain();
    chk("single_q", resp_quotient, 8'h40);
    chk("single_z", resp_div_by_zero, 0);

    // divide by zero
    set_op(2, 8'h10, 8'h00); req_valid = 4'b0100; step(); req_valid = 0;
    drain();
    chk("dbz_flag", resp_div_by_zero, 1);
    chk("dbz_id", resp_id, 2);

    // fairness from rr_ptr = 0
    do_reset();
    grant_id_log.delete(); resp_id_log.delete(); resp_cyc_log.delete();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(16 * (i + 1)), 8'(i + 3));
    req_valid = 4'b1111; step(8); req_valid = 0;
    drain();
    chk("fair_count", grant_id_log.size(), 8);
    chk("fair_resp_count", resp_id_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_id_log.size()) chk("fair_grant", grant_id_log[i], i % 4);
      if (i < resp_id_log.size()) chk("fair_resp_order", resp_id_log[i], i % 4);
      if (i > 0 && i < resp_cyc_log.size()) chk("fair_b2b", resp_cyc_log[i] - resp_cyc_log[i-1], 1);
    end

    // credit cap on requester 1
    grant_id_log.delete(); grant_cyc_log.delete(); resp_id_log.delete(); resp_cyc_log.delete();
    set_op(1, 8'h33, 8'h07); req_valid = 4'b0010;
    k = 0;
    while (grant_id_log.size() < 5 && k < 30) begin step(); k++; end
    req_valid = 0;
    chk("cap_fifth_grant", grant_id_log.size(), 5);
    drain();
    if (grant_cyc_log.size() >= 5 && resp_cyc_log.size() >= 1) begin
      chk("cap_first4_b2b", grant_cyc_log[3] - grant_cyc_log[0], 3);
      chk("cap_fifth_with_resp", grant_cyc_log[4], resp_cyc_log[0]);
      chk("cap_fifth_delay", grant_cyc_log[4] - grant_cyc_log[0], LAT + 1);
    end else begin
      chk("cap_logs", grant_cyc_log.size() * 10 + resp_cyc_log.size(), 51);
    end

    // reset mid-flight
    set_op(0, 8'h11, 8'h02); set_op(1, 8'h22, 8'h03); set_op(3, 8'h44, 8'h05);
    req_valid = 4'b1011; step(3); req_valid = 0; step();
    base = resp_id_log.size();
    do_reset();
    step(15);
    chk("rst_no_resp", resp_id_log.size(), base);
    chk("rst_idle_after", idle, 1);
    set_op(3, 8'h30, 8'h60); req_valid = 4'b1000; step(); req_valid = 0;
    drain();
    chk("rst_fresh_id", resp_id, 3);
    chk("rst_fresh_q", resp_quotient, 8'h40);

    // protocol check
    force_dv = 1; step(); force_dv = 0;
    step(4);
    chk("proto_held", proto_err, 1);
    do_reset();
    chk("proto_cleared", proto_err, 0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        set_op(i, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      step();
    end
    req_valid = 0;
    drain();
    chk("final_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
